uart_tx_ctrl: RTL and testbench



---
 rtl/uart_tx_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter: TX FIFO, programmable baud divisor, polled status.
// Define UART_TX_PARITY_EN to append an even-parity bit to every frame (8E1 instead of 8N1).
module uart_tx_ctrl #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_we_i,
    input  logic [31:0] mem_raddr_i,
    output logic [31:0] mem_rdata_o,
    output logic        uart_txd_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    // Bus decode
    logic [1:0] wr_sel;
    logic [1:0] rd_sel;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;

    // Registers
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          ovf_reg;
    logic          en_reg;
    logic [15:0]   bauddiv_reg;

    // Transmitter
    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic        txd_reg, txd_next;
    logic        bit_done;
`ifdef UART_TX_PARITY_EN
    logic        parity_reg, parity_next;
`endif

    logic unused_bits;
    assign unused_bits = ^{mem_waddr_i[31:4], mem_waddr_i[1:0], mem_raddr_i[31:4],
                           mem_raddr_i[1:0], mem_wdata_i[31:16], mem_we_i[3:2]};

    assign wr_sel     = mem_waddr_i[3:2];
    assign rd_sel     = mem_raddr_i[3:2];
    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign push_req   = mem_we_i[0] && (wr_sel == 2'd0);
    // Full is judged on the pre-pop count, so a push racing a pop is still dropped.
    assign push_ok    = push_req && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr_reg];
    assign count_next = count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= mem_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
            en_reg      <= 1'b0;
            bauddiv_reg <= DEFAULT_DIV;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            if (push_req && fifo_full) begin
                ovf_reg <= 1'b1;
            end else if (mem_we_i[0] && (wr_sel == 2'd1) && mem_wdata_i[3]) begin
                ovf_reg <= 1'b0;
            end
            if (wr_sel == 2'd2) begin
                if (mem_we_i[0]) bauddiv_reg[7:0]  <= mem_wdata_i[7:0];
                if (mem_we_i[1]) bauddiv_reg[15:8] <= mem_wdata_i[15:8];
            end
            if (mem_we_i[0] && (wr_sel == 2'd3)) begin
                en_reg <= mem_wdata_i[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            txd_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            txd_reg     <= txd_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    assign bit_done = (cnt_reg == 16'd0);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        txd_next     = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (en_reg && !fifo_empty) begin
                    state_next = ST_START;
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    cnt_next   = bauddiv_reg;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^fifo_head;
`endif
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_next   = ST_DATA;
                    bit_idx_next = 3'd0;
                    cnt_next     = bauddiv_reg;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_next = bauddiv_reg;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_next = ST_STOP;
                    cnt_next   = bauddiv_reg;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    // Chain straight into the next frame when data is waiting.
                    if (en_reg && !fifo_empty) begin
                        state_next = ST_START;
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        cnt_next   = bauddiv_reg;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^fifo_head;
`endif
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Line level is derived from the next state so the pin comes straight off a flop.
        case (state_next)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_next = parity_next;
`endif
            default:   txd_next = 1'b1;
        endcase
    end

    assign uart_txd_o = txd_reg;

    always_comb begin
        mem_rdata_o = 32'd0;
        case (rd_sel)
            2'd1: mem_rdata_o = {16'd0, 8'(count_reg), 4'd0, ovf_reg, fifo_empty,
                                 fifo_full, (state_reg != ST_IDLE)};
            2'd2: mem_rdata_o = {16'd0, bauddiv_reg};
            2'd3: mem_rdata_o = {31'd0, en_reg};
            default: mem_rdata_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl: register vectors from a table, frame sequences by hand.
// Build with UART_TX_PARITY_EN to also exercise the parity frame.
module tb_uart_tx_ctrl;

    localparam logic [31:0] A_TXDATA  = 32'h0;
    localparam logic [31:0] A_STATUS  = 32'h4;
    localparam logic [31:0] A_BAUDDIV = 32'h8;
    localparam logic [31:0] A_CTRL    = 32'hC;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_we_i;
    logic [31:0] mem_raddr_i;
    logic [31:0] mem_rdata_o;
    logic        uart_txd_o;

    int checks   = 0;
    int failures = 0;

    uart_tx_ctrl #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd867)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_we_i    (mem_we_i),
        .mem_raddr_i (mem_raddr_i),
        .mem_rdata_o (mem_rdata_o),
        .uart_txd_o  (uart_txd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] val;   // write data, or expected read data
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
        @(negedge clk);
        mem_waddr_i = addr;
        mem_wdata_i = data;
        mem_we_i    = we;
        @(negedge clk);
        mem_we_i    = 4'd0;
        $display("WR addr=0x%h we=%b data=0x%08h", addr, we, data);
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        mem_raddr_i = addr;
        #1;
        check(name, mem_rdata_o, exp);
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
`ifdef UART_TX_PARITY_EN
        if (p == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    logic [7:0] b2b_bytes [4];
    logic       a5_bits   [10];
`ifdef UART_TX_PARITY_EN
    logic       p07_bits  [11];
`endif

    initial begin
        vecs[0]  = '{1'b0, A_STATUS,  4'b0000, 32'h0000_0004};
        vecs[1]  = '{1'b0, A_BAUDDIV, 4'b0000, 32'h0000_0363};
        vecs[2]  = '{1'b0, A_CTRL,    4'b0000, 32'h0000_0000};
        vecs[3]  = '{1'b0, A_TXDATA,  4'b0000, 32'h0000_0000};
        vecs[4]  = '{1'b1, A_BAUDDIV, 4'b0011, 32'h0000_1234};
        vecs[5]  = '{1'b0, A_BAUDDIV, 4'b0000, 32'h0000_1234};
        vecs[6]  = '{1'b1, A_BAUDDIV, 4'b0001, 32'hFFFF_FF07};
        vecs[7]  = '{1'b0, A_BAUDDIV, 4'b0000, 32'h0000_1207};
        vecs[8]  = '{1'b1, A_TXDATA,  4'b0010, 32'h0000_0099};
        vecs[9]  = '{1'b0, A_STATUS,  4'b0000, 32'h0000_0004};
        vecs[10] = '{1'b1, A_BAUDDIV, 4'b0011, 32'h0000_0003};
        vecs[11] = '{1'b0, A_BAUDDIV, 4'b0000, 32'h0000_0003};
        vecs[12] = '{1'b1, A_TXDATA,  4'b0001, 32'h0000_0011};
        vecs[13] = '{1'b1, A_TXDATA,  4'b0001, 32'h0000_0022};
        vecs[14] = '{1'b1, A_TXDATA,  4'b0001, 32'h0000_0033};
        vecs[15] = '{1'b1, A_TXDATA,  4'b0001, 32'h0000_0044};
        vecs[16] = '{1'b1, A_TXDATA,  4'b0001, 32'h0000_0055};
        vecs[17] = '{1'b0, A_STATUS,  4'b0000, 32'h0000_040A};
        vecs[18] = '{1'b1, A_STATUS,  4'b0001, 32'h0000_0008};
        vecs[19] = '{1'b0, A_STATUS,  4'b0000, 32'h0000_0402};

        b2b_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        a5_bits   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef UART_TX_PARITY_EN
        p07_bits  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif

        rst_n       = 1'b0;
        mem_waddr_i = '0;
        mem_wdata_i = '0;
        mem_we_i    = '0;
        mem_raddr_i = '0;
        repeat (2) @(negedge clk);
        check("txd_in_reset", {31'd0, uart_txd_o}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Register map, byte enables and overflow, all with the transmitter disabled
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].we, vecs[i].val);
            end else begin
                read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].val);
            end
        end

        // Four queued bytes at bauddiv=0 go out with no gap between frames
        bus_write(A_BAUDDIV, 4'b0011, 32'h0);
        bus_write(A_CTRL, 4'b0001, 32'h1);
        @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            for (int p = 0; p < FRAME; p++) begin
                check($sformatf("b2b_f%0d_b%0d", f, p), {31'd0, uart_txd_o},
                      {31'd0, exp_bit(b2b_bytes[f], p)});
                @(negedge clk);
            end
        end
        read_check("b2b_status_end", A_STATUS, 32'h0000_0004);
        check("b2b_txd_idle", {31'd0, uart_txd_o}, 32'd1);

        // 0xA5 at bauddiv=3: every level held four cycles
        bus_write(A_BAUDDIV, 4'b0011, 32'h3);
        bus_write(A_TXDATA, 4'b0001, 32'hA5);
        @(negedge clk);
        read_check("a5_busy", A_STATUS, 32'h0000_0005);
        for (int p = 0; p < FRAME; p++) begin
            for (int c = 0; c < 4; c++) begin
`ifdef UART_TX_PARITY_EN
                check($sformatf("a5_b%0d_c%0d", p, c), {31'd0, uart_txd_o},
                      {31'd0, exp_bit(8'hA5, p)});
`else
                check($sformatf("a5_b%0d_c%0d", p, c), {31'd0, uart_txd_o}, {31'd0, a5_bits[p]});
`endif
                @(negedge clk);
            end
        end
        read_check("a5_status_end", A_STATUS, 32'h0000_0004);

`ifdef UART_TX_PARITY_EN
        bus_write(A_BAUDDIV, 4'b0011, 32'h0);
        bus_write(A_TXDATA, 4'b0001, 32'h07);
        @(negedge clk);
        for (int p = 0; p < 11; p++) begin
            check($sformatf("par07_b%0d", p), {31'd0, uart_txd_o}, {31'd0, p07_bits[p]});
            @(negedge clk);
        end
        read_check("par07_status_end", A_STATUS, 32'h0000_0004);
        bus_write(A_BAUDDIV, 4'b0011, 32'h3);
`endif

        // Dropping en mid-frame lets the frame finish and keeps the rest of the FIFO
        bus_write(A_CTRL, 4'b0001, 32'h0);
        bus_write(A_TXDATA, 4'b0001, 32'h0F);
        bus_write(A_TXDATA, 4'b0001, 32'hF0);
        read_check("enclr_count2", A_STATUS, 32'h0000_0200);
        bus_write(A_CTRL, 4'b0001, 32'h1);
        repeat (3) @(negedge clk);
        bus_write(A_CTRL, 4'b0001, 32'h0);
        repeat (20) @(negedge clk);
        read_check("enclr_midframe", A_STATUS, 32'h0000_0101);
        repeat (30) @(negedge clk);
        read_check("enclr_retained", A_STATUS, 32'h0000_0100);
        check("enclr_txd_idle", {31'd0, uart_txd_o}, 32'd1);

        // Asynchronous reset in the middle of a frame
        bus_write(A_CTRL, 4'b0001, 32'h1);
        repeat (8) @(negedge clk);
        read_check("rst_pre_busy", A_STATUS, 32'h0000_0005);
        check("rst_pre_txd_low", {31'd0, uart_txd_o}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_txd", {31'd0, uart_txd_o}, 32'd1);
        read_check("rst_status", A_STATUS, 32'h0000_0004);
        read_check("rst_ctrl", A_CTRL, 32'h0000_0000);
        read_check("rst_bauddiv", A_BAUDDIV, 32'h0000_0363);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        read_check("post_rst_status", A_STATUS, 32'h0000_0004);
        check("post_rst_txd", {31'd0, uart_txd_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
